// File: rtl/piso_seq_pkg.sv
// Shared types and constants for the parallel-in/serial-out select sequencer.
// The select ordering helpers let the top and counter agree on the first/last mux position.
package piso_seq_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [2:0] sel_first(input logic msb_first);
        return msb_first ? 3'd7 : 3'd0;
    endfunction

    function automatic logic [2:0] sel_last(input logic msb_first);
        return msb_first ? 3'd0 : 3'd7;
    endfunction

endpackage

// File: rtl/sel_counter3.sv
// 3-bit up/down select counter with synchronous load and enable.
// o_at_last flags the final mux position so the FSM can leave SHIFT without wrapping.
module sel_counter3 #(
    parameter logic [2:0] RST_VAL  = 3'd0,
    parameter logic [2:0] LAST_VAL = 3'd7,
    parameter bit         DOWN     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    input  logic       i_en,
    output logic [2:0] o_sel,
    output logic       o_at_last
);

    logic [2:0] r_sel;

    // Load wins over enable so a new word always restarts at the first position.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel <= RST_VAL;
        end else if (i_load) begin
            r_sel <= i_load_val;
        end else if (i_en) begin
            r_sel <= DOWN ? (r_sel - 3'd1) : (r_sel + 3'd1);
        end
    end

    assign o_sel     = r_sel;
    assign o_at_last = (r_sel == LAST_VAL);

endmodule

// File: rtl/piso_sel_sequencer.sv
// Holds a parallel word on the 8:1 mux data inputs and walks the select through all positions,
// turning mux Y into a serial stream with valid/last flags and an end-of-word done pulse.
module piso_sel_sequencer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_step_en,
    output logic [WIDTH-1:0] o_d_out,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_ser_valid,
    output logic             o_ser_last,
    output logic             o_done
);

    import piso_seq_pkg::*;

    // The mux is fixed at 8:1, so any other geometry is a build error.
    if (WIDTH != piso_seq_pkg::WORD_W || SEL_W != piso_seq_pkg::SEL_W) begin : g_param_check
        $error("piso_sel_sequencer supports only WIDTH=8, SEL_W=3");
    end

    localparam logic [2:0] SEL_FIRST = sel_first(MSB_FIRST);
    localparam logic [2:0] SEL_LAST  = sel_last(MSB_FIRST);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_d_out;
    logic             w_accept;
    logic             w_load;
    logic             w_step;
    logic             w_at_last;
    logic [2:0]       w_sel;

    assign o_load_ready = (r_state != SHIFT);
    assign w_accept     = i_load_valid && o_load_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // DONE accepts directly into SHIFT so back-to-back words cost 9 cycles each.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (i_step_en) begin
                    if (w_at_last) begin
                        w_next_state = DONE;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_d_out <= '0;
        end else if (w_load) begin
            r_d_out <= i_load_data;
        end
    end

    sel_counter3 #(
        .RST_VAL  (SEL_FIRST),
        .LAST_VAL (SEL_LAST),
        .DOWN     (MSB_FIRST)
    ) u_sel_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (SEL_FIRST),
        .i_en       (w_step),
        .o_sel      (w_sel),
        .o_at_last  (w_at_last)
    );

    assign o_d_out     = r_d_out;
    assign o_sel       = w_sel;
    assign o_ser_valid = (r_state == SHIFT);
    assign o_ser_last  = (r_state == SHIFT) && w_at_last;
    assign o_done      = (r_state == DONE);

endmodule

// File: tb/tb_piso_sel_sequencer.sv
// Table-driven bench for piso_sel_sequencer, with hand-written sequences for mid-word reset
// and the MSB-first ordering on a second instance.
module tb_piso_sel_sequencer;

    typedef struct {
        bit         rstN;
        bit         lv;
        logic [7:0] data;
        bit         step;
        bit         eReady;
        logic [7:0] eDout;
        logic [2:0] eSel;
        bit         eValid;
        bit         eLast;
        bit         eDone;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       step_en;

    logic       ready0, valid0, last0, done0;
    logic [7:0] dOut0;
    logic [2:0] sel0;
    logic       ready1, valid1, last1, done1;
    logic [7:0] dOut1;
    logic [2:0] sel1;

    int   nCompared   = 0;
    int   nMismatched = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    piso_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) u_dut0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_valid (load_valid),
        .o_load_ready (ready0),
        .i_load_data  (load_data),
        .i_step_en    (step_en),
        .o_d_out      (dOut0),
        .o_sel        (sel0),
        .o_ser_valid  (valid0),
        .o_ser_last   (last0),
        .o_done       (done0)
    );

    piso_sel_sequencer #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) u_dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_valid (load_valid),
        .o_load_ready (ready1),
        .i_load_data  (load_data),
        .i_step_en    (step_en),
        .o_d_out      (dOut1),
        .o_sel        (sel1),
        .o_ser_valid  (valid1),
        .o_ser_last   (last1),
        .o_done       (done1)
    );

    function automatic void addRow(bit r, bit lv, logic [7:0] d, bit st, bit eRdy,
                                   logic [7:0] eD, logic [2:0] eS, bit eV, bit eL, bit eDn);
        vec_t v;
        v.rstN = r; v.lv = lv; v.data = d; v.step = st;
        v.eReady = eRdy; v.eDout = eD; v.eSel = eS; v.eValid = eV; v.eLast = eL; v.eDone = eDn;
        vecs.push_back(v);
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic applyStimulus(input bit r, input bit lv, input logic [7:0] d, input bit st);
        rst_n      = r;
        load_valid = lv;
        load_data  = d;
        step_en    = st;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] req);
        nCompared++;
        if (act !== req) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic checkOutput(input bit which, input bit eRdy, input logic [7:0] eD,
                               input logic [2:0] eS, input bit eV, input bit eL, input bit eDn);
        logic [7:0] expY;
        expY = {7'd0, eD[eS]};
        if (!which) begin
            checkVal("lsb.load_ready", {7'd0, ready0}, {7'd0, eRdy});
            checkVal("lsb.d_out", dOut0, eD);
            checkVal("lsb.sel", {5'd0, sel0}, {5'd0, eS});
            checkVal("lsb.ser_valid", {7'd0, valid0}, {7'd0, eV});
            checkVal("lsb.ser_last", {7'd0, last0}, {7'd0, eL});
            checkVal("lsb.done", {7'd0, done0}, {7'd0, eDn});
            if (eV) checkVal("lsb.mux_y", {7'd0, dOut0[sel0]}, expY);
        end else begin
            checkVal("msb.load_ready", {7'd0, ready1}, {7'd0, eRdy});
            checkVal("msb.d_out", dOut1, eD);
            checkVal("msb.sel", {5'd0, sel1}, {5'd0, eS});
            checkVal("msb.ser_valid", {7'd0, valid1}, {7'd0, eV});
            checkVal("msb.ser_last", {7'd0, last1}, {7'd0, eL});
            checkVal("msb.done", {7'd0, done1}, {7'd0, eDn});
            if (eV) checkVal("msb.mux_y", {7'd0, dOut1[sel1]}, expY);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        step_en    = 1'b0;

        // Reset held two cycles while a word is offered: nothing is accepted.
        addRow(0, 1, 8'hFF, 1, 1, 8'h00, 3'd0, 0, 0, 0);
        addRow(0, 1, 8'hFF, 1, 1, 8'h00, 3'd0, 0, 0, 0);

        // Basic word A5, unstalled.
        addRow(1, 1, 8'hA5, 1, 0, 8'hA5, 3'd0, 1, 0, 0);
        for (int i = 1; i < 8; i++) addRow(1, 0, 8'h00, 1, 0, 8'hA5, 3'(i), 1, i == 7, 0);
        addRow(1, 0, 8'h00, 1, 1, 8'hA5, 3'd7, 0, 0, 1);
        addRow(1, 0, 8'h00, 1, 1, 8'hA5, 3'd7, 0, 0, 0);

        // Same word with a two-cycle stall at sel=3; step_en low in IDLE does not block the load.
        addRow(1, 1, 8'hA5, 0, 0, 8'hA5, 3'd0, 1, 0, 0);
        for (int i = 1; i < 4; i++) addRow(1, 0, 8'h00, 1, 0, 8'hA5, 3'(i), 1, 0, 0);
        addRow(1, 0, 8'h00, 0, 0, 8'hA5, 3'd3, 1, 0, 0);
        addRow(1, 0, 8'h00, 0, 0, 8'hA5, 3'd3, 1, 0, 0);
        for (int i = 4; i < 8; i++) addRow(1, 0, 8'h00, 1, 0, 8'hA5, 3'(i), 1, i == 7, 0);
        addRow(1, 0, 8'h00, 1, 1, 8'hA5, 3'd7, 0, 0, 1);
        addRow(1, 0, 8'h00, 1, 1, 8'hA5, 3'd7, 0, 0, 0);

        // Back-to-back: 3C then FF offered throughout SHIFT, taken in the DONE cycle.
        addRow(1, 1, 8'h3C, 1, 0, 8'h3C, 3'd0, 1, 0, 0);
        for (int i = 1; i < 8; i++) addRow(1, 1, 8'hFF, 1, 0, 8'h3C, 3'(i), 1, i == 7, 0);
        addRow(1, 1, 8'hFF, 1, 1, 8'h3C, 3'd7, 0, 0, 1);
        addRow(1, 1, 8'hFF, 1, 0, 8'hFF, 3'd0, 1, 0, 0);
        for (int i = 1; i < 8; i++) addRow(1, 0, 8'h00, 1, 0, 8'hFF, 3'(i), 1, i == 7, 0);
        addRow(1, 0, 8'h00, 1, 1, 8'hFF, 3'd7, 0, 0, 1);
        addRow(1, 0, 8'h00, 1, 1, 8'hFF, 3'd7, 0, 0, 0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rstN, vecs[k].lv, vecs[k].data, vecs[k].step);
            checkOutput(1'b0, vecs[k].eReady, vecs[k].eDout, vecs[k].eSel,
                        vecs[k].eValid, vecs[k].eLast, vecs[k].eDone);
        end

        // Reset mid-word at sel=5: partial word dropped, no done pulse, next load restarts at 0.
        applyStimulus(1, 1, 8'h5A, 1);
        checkOutput(1'b0, 0, 8'h5A, 3'd0, 1, 0, 0);
        repeat (5) applyStimulus(1, 0, 8'h00, 1);
        checkOutput(1'b0, 0, 8'h5A, 3'd5, 1, 0, 0);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput(1'b0, 1, 8'h00, 3'd0, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 1);
        checkOutput(1'b0, 1, 8'h00, 3'd0, 0, 0, 0);
        applyStimulus(1, 0, 8'h00, 1);
        checkOutput(1'b0, 1, 8'h00, 3'd0, 0, 0, 0);
        applyStimulus(1, 1, 8'h81, 1);
        checkOutput(1'b0, 0, 8'h81, 3'd0, 1, 0, 0);

        // MSB-first instance: reset puts sel at 7, word 80 yields a single leading 1.
        applyStimulus(0, 0, 8'h00, 0);
        checkOutput(1'b1, 1, 8'h00, 3'd7, 0, 0, 0);
        applyStimulus(1, 1, 8'h80, 1);
        checkOutput(1'b1, 0, 8'h80, 3'd7, 1, 0, 0);
        for (int i = 6; i >= 0; i--) begin
            applyStimulus(1, 0, 8'h00, 1);
            checkOutput(1'b1, 0, 8'h80, 3'(i), 1, i == 0, 0);
        end
        applyStimulus(1, 0, 8'h00, 1);
        checkOutput(1'b1, 1, 8'h80, 3'd0, 0, 0, 1);
        applyStimulus(1, 0, 8'h00, 1);
        checkOutput(1'b1, 1, 8'h80, 3'd0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
